// File: rtl/part_counter_ud.sv
// Parametrised S169-style synchronous up/down counter with configurable modulus,
// wrap/saturate mode, asynchronous reset and a registered wrap pulse.
module part_counter_ud #(
    parameter int              WIDTH     = 4,
    parameter longint unsigned MODULUS   = 16,
    parameter longint unsigned RESET_VAL = 0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] I,
    input  logic             LOAD_N,
    input  logic             UP_DN,
    input  logic             ENB_P_N,
    input  logic             ENB_T_N,
    input  logic             SAT,
    output logic [WIDTH-1:0] O,
    output logic             CO_N,
    output logic             WRAP_Q
);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("part_counter_ud: WIDTH must be in 2..32");
        end
        if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
            $error("part_counter_ud: MODULUS must be in 2..2^WIDTH");
        end
        if (RESET_VAL >= MODULUS) begin : g_bad_reset_val
            $error("part_counter_ud: RESET_VAL must be below MODULUS");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL   = WIDTH'(RESET_VAL);
    localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH+1)'(MODULUS);

    logic [WIDTH-1:0] o_q, o_d;
    logic             wrap_q, wrap_d;
    logic             tc;

    // Terminal count depends on the live direction, so a direction change
    // re-arms the carry without waiting for an edge.
    always_comb begin
        tc = UP_DN ? (o_q == MAX_VAL) : (o_q == '0);
    end

    always_comb begin
        o_d    = o_q;
        wrap_d = 1'b0;
        if (!LOAD_N) begin
            o_d = ({1'b0, I} < MOD_EXT) ? I : MAX_VAL;
        end else if (!ENB_P_N && !ENB_T_N) begin
            if (!tc) begin
                o_d = UP_DN ? (o_q + WIDTH'(1)) : (o_q - WIDTH'(1));
            end else if (!SAT) begin
                o_d    = UP_DN ? '0 : MAX_VAL;
                wrap_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            o_q    <= RST_VAL;
            wrap_q <= 1'b0;
        end else begin
            o_q    <= o_d;
            wrap_q <= wrap_d;
        end
    end

    assign O      = o_q;
    assign WRAP_Q = wrap_q;
    assign CO_N   = !(tc && !ENB_T_N);

endmodule

// File: tb/tb_part_counter_ud.sv
// Bench for part_counter_ud: modulus-10 directed tests, a two-stage cascade and a
// randomised modulus-16 run, all checked against an arithmetic counter model.
module tb_part_counter_ud;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;
    logic rand_done = 1'b0;

    // modulus-10 instance
    logic [3:0] i10 = '0;
    logic ld10 = 1'b1, ud10 = 1'b1, p10 = 1'b1, t10 = 1'b1, sat10 = 1'b0;
    logic [3:0] o10;
    logic co10, w10;

    part_counter_ud #(.WIDTH(4), .MODULUS(10), .RESET_VAL(3)) dut10 (
        .CLK(clk), .RESET(rst), .I(i10), .LOAD_N(ld10), .UP_DN(ud10),
        .ENB_P_N(p10), .ENB_T_N(t10), .SAT(sat10),
        .O(o10), .CO_N(co10), .WRAP_Q(w10));

    // modulus-16 instance, randomised S169 equivalence
    logic [3:0] i16 = '0;
    logic ld16 = 1'b1, ud16 = 1'b1, p16 = 1'b1, t16 = 1'b1, sat16 = 1'b0;
    logic [3:0] o16;
    logic co16, w16;

    part_counter_ud #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) dut16 (
        .CLK(clk), .RESET(rst), .I(i16), .LOAD_N(ld16), .UP_DN(ud16),
        .ENB_P_N(p16), .ENB_T_N(t16), .SAT(sat16),
        .O(o16), .CO_N(co16), .WRAP_Q(w16));

    // two-stage cascade
    logic [3:0] ihi = 4'hF, ilo = 4'hE;
    logic ldc = 1'b1, pc = 1'b1, tc_lo = 1'b1;
    logic [3:0] ohi, olo;
    logic co_hi, co_lo, whi, wlo;

    part_counter_ud #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) dut_lo (
        .CLK(clk), .RESET(rst), .I(ilo), .LOAD_N(ldc), .UP_DN(1'b1),
        .ENB_P_N(pc), .ENB_T_N(tc_lo), .SAT(1'b0),
        .O(olo), .CO_N(co_lo), .WRAP_Q(wlo));

    part_counter_ud #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) dut_hi (
        .CLK(clk), .RESET(rst), .I(ihi), .LOAD_N(ldc), .UP_DN(1'b1),
        .ENB_P_N(pc), .ENB_T_N(co_lo), .SAT(1'b0),
        .O(ohi), .CO_N(co_hi), .WRAP_Q(whi));

    // Counter model: plain integer arithmetic on the value range 0..mod-1.
    function automatic void model_step(input int mod, input int o, input logic ld_n,
                                       input int i, input logic up, input logic p_n,
                                       input logic t_n, input logic sat,
                                       output int o_n, output logic w);
        int n;
        o_n = o;
        w   = 1'b0;
        if (!ld_n) begin
            o_n = (i < mod) ? i : mod - 1;
        end else if (!p_n && !t_n) begin
            n = up ? o + 1 : o - 1;
            if (n >= 0 && n < mod) o_n = n;
            else if (!sat) begin
                o_n = (n + mod) % mod;
                w   = 1'b1;
            end
        end
    endfunction

    function automatic logic model_co_n(input int mod, input int o, input logic up,
                                        input logic t_n);
        return !(!t_n && (up ? (o == mod - 1) : (o == 0)));
    endfunction

    int   m10 = 3, m16 = 0;
    logic mw10 = 1'b0, mw16 = 1'b0;

    always @(posedge clk or posedge rst) begin
        int nv;
        logic nw;
        if (rst) begin
            m10 = 3; mw10 = 1'b0;
            m16 = 0; mw16 = 1'b0;
        end else begin
            model_step(10, m10, ld10, int'(i10), ud10, p10, t10, sat10, nv, nw);
            m10 = nv; mw10 = nw;
            model_step(16, m16, ld16, int'(i16), ud16, p16, t16, sat16, nv, nw);
            m16 = nv; mw16 = nw;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle model comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("mod10_O", {28'd0, o10}, m10);
            check("mod10_WRAP_Q", {31'd0, w10}, {31'd0, mw10});
            check("mod10_CO_N", {31'd0, co10}, {31'd0, model_co_n(10, m10, ud10, t10)});
            check("s169_O", {28'd0, o16}, m16);
            check("s169_WRAP_Q", {31'd0, w16}, {31'd0, mw16});
            check("s169_CO_N", {31'd0, co16}, {31'd0, model_co_n(16, m16, ud16, t16)});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Random S169 stimulus, running alongside the directed sequence.
    initial begin
        @(negedge rst);
        for (int k = 0; k < 2000; k++) begin
            tick();
            i16  = 4'($urandom_range(0, 15));
            ld16 = ($urandom_range(0, 7) != 0);
            ud16 = 1'($urandom);
            p16  = ($urandom_range(0, 4) == 0);
            t16  = ($urandom_range(0, 4) == 0);
        end
        rand_done = 1'b1;
    end

    initial begin
        #1 rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;

        // asynchronous reset between edges
        ld10 = 1'b0; i10 = 4'd6;
        tick();
        ld10 = 1'b1;
        check("load_before_reset", {28'd0, o10}, 32'd6);
        rst = 1'b1;
        #1;
        check("async_reset_O", {28'd0, o10}, 32'd3);
        check("async_reset_WRAP_Q", {31'd0, w10}, 32'd0);
        check("async_reset_CO_N", {31'd0, co10}, 32'd1);
        tick();
        rst = 1'b0;
        ud10 = 1'b1; p10 = 1'b0; t10 = 1'b0; sat10 = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("up_count_O", {28'd0, o10}, (3 + k) % 10);
            check("up_count_WRAP_Q", {31'd0, w10}, (k == 7) ? 32'd1 : 32'd0);
        end

        // down wrap and carry
        ld10 = 1'b0; i10 = 4'd0;
        tick();
        ld10 = 1'b0; ld10 = 1'b1; ud10 = 1'b0;
        #1;
        check("down_tc_CO_N", {31'd0, co10}, 32'd0);
        tick();
        check("down_wrap_O", {28'd0, o10}, 32'd9);
        check("down_wrap_WRAP_Q", {31'd0, w10}, 32'd1);
        t10 = 1'b1;
        #1;
        check("t_disable_CO_N", {31'd0, co10}, 32'd1);
        tick();
        check("t_disable_hold_O", {28'd0, o10}, 32'd9);
        check("t_disable_WRAP_Q", {31'd0, w10}, 32'd0);

        // saturate at the top, then count down
        sat10 = 1'b1; ld10 = 1'b0; i10 = 4'd9;
        tick();
        ld10 = 1'b1; ud10 = 1'b1; p10 = 1'b0; t10 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("sat_CO_N", {31'd0, co10}, 32'd0);
            tick();
            check("sat_hold_O", {28'd0, o10}, 32'd9);
            check("sat_WRAP_Q", {31'd0, w10}, 32'd0);
        end
        ud10 = 1'b0;
        tick();
        check("sat_down1_O", {28'd0, o10}, 32'd8);
        tick();
        check("sat_down2_O", {28'd0, o10}, 32'd7);

        // load priority and clamp
        sat10 = 1'b0; ud10 = 1'b1; ld10 = 1'b0; i10 = 4'hC;
        tick();
        check("load_clamp_O", {28'd0, o10}, 32'd9);
        i10 = 4'd5;
        tick();
        check("load_over_tc_O", {28'd0, o10}, 32'd5);
        check("load_over_tc_WRAP_Q", {31'd0, w10}, 32'd0);
        ld10 = 1'b1; p10 = 1'b1; t10 = 1'b1;

        // cascade: hi=F, lo=E then two enabled edges
        ldc = 1'b0;
        tick();
        ldc = 1'b1; pc = 1'b0; tc_lo = 1'b0;
        check("cascade_load", {24'd0, ohi, olo}, 32'hFE);
        tick();
        check("cascade_FF", {24'd0, ohi, olo}, 32'hFF);
        check("cascade_hi_CO_N", {31'd0, co_hi}, 32'd0);
        tick();
        check("cascade_00", {24'd0, ohi, olo}, 32'h00);
        check("cascade_hi_wrap", {31'd0, whi}, 32'd1);
        pc = 1'b1;

        for (int k = 0; k < 3000 && !rand_done; k++) tick();
        if (!rand_done) check("random_run_timeout", 32'd0, 32'd1);
        tick();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
